// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between the requesting masters and the round-robin arbiter.
// The master side drives requests and the mode/lock controls; the slave side returns the grant.
interface rr_req_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic             mode;
  logic             lock;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [ID_W-1:0]  gnt_id;
  logic             preempt;

  modport master (output req, mode, lock, input gnt, gnt_valid, gnt_id, preempt);
  modport slave  (input req, mode, lock, output gnt, gnt_valid, gnt_id, preempt);
endinterface

// File: rtl/rr_req_arbiter.sv
// N-way request arbiter with fixed-priority or round-robin selection.
// Supports a bounded hold time with preemption, which lock suspends; all outputs are registered.
module rr_req_arbiter #(
  parameter  int N_REQ    = 4,
  parameter  int HOLD_MAX = 8,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  rr_req_arbiter_if.slave  bus
);

  localparam int                CNT_W    = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0]  HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0]  HOLD_ONE = CNT_W'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_p0, state_d;
  logic [N_REQ-1:0] gnt_p0, gnt_d;
  logic [ID_W-1:0]  id_p0, id_d;
  logic             pre_p0, pre_d;
  logic             vld_p0;
  logic [ID_W-1:0]  ptr_p0, ptr_d;
  logic [CNT_W-1:0] hold_p0, hold_d;

  logic             do_grant;
  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] others;
  logic [ID_W:0]    win;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Returns {found, index}; round-robin scans upward from ptr with wraparound.
  function automatic logic [ID_W:0] pick(input logic [N_REQ-1:0] c,
                                         input logic              rr,
                                         input logic [ID_W-1:0]   ptr);
    logic            found;
    logic [ID_W-1:0] idx;
    int              j;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      j = rr ? (int'(ptr) + off) % N_REQ : off;
      if (!found && c[j]) begin
        found = 1'b1;
        idx   = ID_W'(j);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] k);
    return (int'(k) == N_REQ - 1) ? '0 : ID_W'(int'(k) + 1);
  endfunction

  always_comb begin
    state_d  = state_p0;
    gnt_d    = gnt_p0;
    id_d     = id_p0;
    pre_d    = 1'b0;
    ptr_d    = ptr_p0;
    hold_d   = hold_p0;
    do_grant = 1'b0;
    cand     = '0;
    others   = bus.req & ~onehot(id_p0);

    case (state_p0)
      IDLE: begin
        if (|bus.req) begin
          do_grant = 1'b1;
          cand     = bus.req;
        end
      end
      GRANT: begin
        if (!bus.req[id_p0]) begin
          if (|others) begin
            do_grant = 1'b1;
            cand     = others;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            hold_d  = '0;
          end
        end else if (HOLD_MAX != 0 && hold_p0 == HOLD_LIM && !bus.lock && |others) begin
          do_grant = 1'b1;
          cand     = others;
          pre_d    = 1'b1;
        end else if (HOLD_MAX != 0 && hold_p0 != HOLD_LIM) begin
          hold_d = hold_p0 + HOLD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    win = pick(cand, bus.mode, ptr_p0);
    if (do_grant && win[ID_W]) begin
      state_d = GRANT;
      gnt_d   = onehot(win[ID_W-1:0]);
      id_d    = win[ID_W-1:0];
      hold_d  = HOLD_ONE;
      ptr_d   = next_ptr(win[ID_W-1:0]);
    end
  end

  // Output/control register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= IDLE;
      gnt_p0   <= '0;
      id_p0    <= '0;
      pre_p0   <= 1'b0;
      vld_p0   <= 1'b0;
      ptr_p0   <= '0;
      hold_p0  <= '0;
    end else begin
      state_p0 <= state_d;
      gnt_p0   <= gnt_d;
      id_p0    <= id_d;
      pre_p0   <= pre_d;
      vld_p0   <= |gnt_d;
      ptr_p0   <= ptr_d;
      hold_p0  <= hold_d;
    end
  end

  assign bus.gnt       = gnt_p0;
  assign bus.gnt_valid = vld_p0;
  assign bus.gnt_id    = id_p0;
  assign bus.preempt   = pre_p0;

endmodule
